// File: rtl/ysyx_22050133_imem_resp.sv
// Instruction-fetch responder: takes one fetch request at a time, issues a
// single aligned 64-bit memory read with fixed latency LAT, and returns the
// 32-bit instruction (upper word shifted down when pc[2] is set) as a
// one-cycle inst_valid_o pulse. Requests below BASE are answered at once
// with err_o. flush_i while a read is in flight drops the response.
// Optional one-line buffer enabled by defining YSYX_22050133_IMEM_LINEBUF_EN;
// the default build has no buffer and ignores inv_i.
module ysyx_22050133_imem_resp #(
  parameter int unsigned LAT  = 2,
  parameter logic [63:0] BASE = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_valid_i,
  input  logic [63:0] pc_i,
  output logic        pc_ready_o,
  input  logic        flush_i,
  input  logic        inv_i,
  output logic [63:0] inst64_o,
  output logic        inst_valid_o,
  output logic        err_o,
  output logic        mem_rd_en_o,
  output logic [63:0] mem_addr_o,
  input  logic [63:0] mem_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  // WAIT lasts LAT-1 cycles; the counter counts down to zero inclusive.
  localparam logic [3:0] CNT_INIT = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

  // Selects the requested word: upper half moves down into [31:0].
  function automatic logic [63:0] pick_word(input logic hi, input logic [63:0] line);
    return hi ? {32'h0, line[63:32]} : line;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        drop_q, drop_d;
  logic        pc2_q, pc2_d;
  logic [63:0] inst64_q, inst64_d;
  logic        inst_valid_q, inst_valid_d;
  logic        err_q, err_d;
  logic        mem_rd_en_q, mem_rd_en_d;
  logic [63:0] mem_addr_q, mem_addr_d;

  logic        accept;
  logic        in_range;
  logic        lb_hit;
  logic [63:0] hit_line;
  logic        resp_ok;

  assign pc_ready_o = (state_q == S_IDLE) && !flush_i;
  assign accept     = pc_valid_i && pc_ready_o;
  assign in_range   = (pc_i >= BASE);
  // A response that is delivered (and may refill the buffer) this cycle.
  assign resp_ok    = (state_q == S_RESP) && !drop_q;

`ifdef YSYX_22050133_IMEM_LINEBUF_EN
  logic        lb_valid_q, lb_valid_d;
  logic [60:0] lb_tag_q, lb_tag_d;
  logic [63:0] lb_data_q, lb_data_d;

  // An invalidate in the accept cycle forces a miss.
  assign lb_hit   = lb_valid_q && !inv_i && (lb_tag_q == pc_i[63:3]);
  assign hit_line = lb_data_q;

  // Buffer refill on every delivered response; inv_i wins over a same-cycle refill.
  always_comb begin
    lb_valid_d = lb_valid_q;
    lb_tag_d   = lb_tag_q;
    lb_data_d  = lb_data_q;
    if (resp_ok) begin
      lb_valid_d = 1'b1;
      lb_tag_d   = mem_addr_q[63:3];
      lb_data_d  = mem_rdata_i;
    end
    if (inv_i) begin
      lb_valid_d = 1'b0;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lb_valid_q <= 1'b0;
      lb_tag_q   <= '0;
      lb_data_q  <= '0;
    end else begin
      lb_valid_q <= lb_valid_d;
      lb_tag_q   <= lb_tag_d;
      lb_data_q  <= lb_data_d;
    end
  end
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign lb_hit     = 1'b0;
  assign hit_line   = 64'h0;
`endif

  // Fetch sequencing: accept, one read strobe, latency wait, respond.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drop_d       = drop_q;
    pc2_d        = pc2_q;
    inst64_d     = inst64_q;
    inst_valid_d = 1'b0;
    err_d        = 1'b0;
    mem_rd_en_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!in_range) begin
            err_d        = 1'b1;
            inst_valid_d = 1'b1;
            inst64_d     = 64'h0;
          end else if (lb_hit) begin
            inst_valid_d = 1'b1;
            inst64_d     = pick_word(pc_i[2], hit_line);
          end else begin
            state_d     = S_REQ;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = {pc_i[63:3], 3'b000};
            pc2_d       = pc_i[2];
            drop_d      = 1'b0;
          end
        end
      end
      S_REQ: begin
        if (flush_i) begin
          drop_d = 1'b1;
        end
        if (LAT == 1) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          drop_d = 1'b1;
        end
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        // Read data is on mem_rdata_i in this cycle.
        state_d = S_IDLE;
        drop_d  = 1'b0;
        if (resp_ok) begin
          inst_valid_d = 1'b1;
          inst64_d     = pick_word(pc2_q, mem_rdata_i);
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      drop_q       <= 1'b0;
      pc2_q        <= 1'b0;
      inst64_q     <= 64'h0;
      inst_valid_q <= 1'b0;
      err_q        <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= 64'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drop_q       <= drop_d;
      pc2_q        <= pc2_d;
      inst64_q     <= inst64_d;
      inst_valid_q <= inst_valid_d;
      err_q        <= err_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign inst64_o     = inst64_q;
  assign inst_valid_o = inst_valid_q;
  assign err_o        = err_q;
  assign mem_rd_en_o  = mem_rd_en_q;
  assign mem_addr_o   = mem_addr_q;

endmodule
